dm_cache: RTL and testbench
===========================

DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 The block SHALL have parameter LINE_ADDR_LEN, default 3, meaning log2 of words per line (8).
REQ-002 The block SHALL have parameter SET_ADDR_LEN, default 2, meaning log2 of set count (4).
REQ-003 The block SHALL have parameter TAG_ADDR_LEN, default 6, meaning tag width; sum of the three widths = 11 = memory word-address width.
REQ-004 The block SHALL have port clk, input, 1, clock.
REQ-005 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 The block SHALL have port rd_req, input, 1, CPU read request, held until miss low.
REQ-007 The block SHALL have port wr_req, input, 1, CPU write request, held until miss low.
REQ-008 The block SHALL have port addr, input, 11, CPU word address {tag,set,offset}.
REQ-009 The block SHALL have port wr_data, input, 32, CPU write data.
REQ-010 The block SHALL have port rd_data, output, 32, CPU read data, valid when rd_req=1 and miss=0.
REQ-011 The block SHALL have port miss, output, 1, stall: request pending and not yet served.
REQ-012 The block SHALL have port mem_addr, output, 11, word address to the downstream memory.
REQ-013 The block SHALL have port mem_wr_req, output, 1, memory write strobe.
REQ-014 The block SHALL have port mem_wr_data, output, 32, memory write data.
REQ-015 The block SHALL have port mem_rd_data, input, 32, memory read data, registered, valid one cycle after mem_addr.

Function
REQ-016 Organisation SHALL be direct-mapped, write-back, write-allocate; per set: valid, dirty, tag, 8x32 data.
REQ-017 hit SHALL be state==IDLE and valid[set] and tag[set]==addr tag; miss = (rd_req|wr_req) and not hit, combinational.
REQ-018 Read hit SHALL return data combinationally in the same cycle (zero-cycle latency).
REQ-019 Write hit SHALL update the addressed word at the clock edge and set dirty[set].
REQ-020 rd_req and wr_req both high SHALL be treated as a write; the read data is don't-care.
REQ-021 FSM states SHALL be IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
REQ-022 IDLE with request and no hit SHALL transition to SWAP_OUT if valid and dirty, else to SWAP_IN; set index and tag are latched on this transition.
REQ-023 SWAP_OUT SHALL last 8 cycles with count 0..7: mem_addr={old tag,set,count}, mem_wr_req=1, mem_wr_data=line word count; then go to SWAP_IN.
REQ-024 SWAP_IN SHALL last 9 cycles with count 0..8: for count<8 drive mem_addr={new tag,set,count}; for count>=1 capture mem_rd_data into word count-1; mem_wr_req=0.
REQ-025 SWAP_IN_OK SHALL last one cycle: write tag, valid=1, dirty=0; then go to IDLE, where the request hits.
REQ-026 Miss latency SHALL be 11 cycles of miss=1 for a clean miss and 19 for a dirty miss; the request is served on the following cycle.
REQ-027 Outside SWAP_OUT, mem_wr_req SHALL be 0; mem_addr and mem_wr_data are don't-care unless otherwise specified.
REQ-028 The counter SHALL wrap to 0 at every state exit; requests arriving while not in IDLE are ignored until IDLE.

Reset
REQ-029 rst SHALL immediately clear all valid and dirty bits, set the FSM to IDLE, clear the counter, and drive mem_wr_req=0; data and tag arrays are not reset.
REQ-030 rst asserted mid-SWAP_OUT or mid-SWAP_IN SHALL abandon the transfer; memory may hold a partially written line; no line is valid after reset.

Structure
REQ-031 Package cache_pkg SHALL hold the FSM state enum, default width constants, and a line-word typedef.
REQ-032 No sub-module SHALL be used; arrays are inline; the memory is instantiated beside the cache at the top level, not inside it.

Verification
REQ-033 After reset with memory word k preloaded, a read of addr 0 SHALL hold miss high for 11 cycles, then return rd_data=0x0000000c.
REQ-034 After REQ-033, reads of addr 1 and addr 7 SHALL hit with miss=0 and return 0x000000a8 and 0x00000087 in the same cycle.
REQ-035 A write to addr 2 of 0xDEADBEEF, then a read of addr 2, SHALL hit both times and return 0xDEADBEEF; memory word 2 SHALL still read 0x00000034.
REQ-036 Following REQ-035, a read of addr 32 (same set, tag 1) SHALL hold miss for 19 cycles with 8 writes to memory 0..7, leaving memory word 2 = 0xDEADBEEF; rd_data SHALL be 0x00000099.
REQ-037 rst pulsed at SWAP_IN count 4, then a read of addr 0, SHALL hold miss for 11 cycles and return 0x0000000c.
REQ-038 Simultaneous rd_req and wr_req to addr 3 with 0x55 SHALL be performed as a write; a later read of addr 3 SHALL return 0x00000055.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back cache.
package cache_pkg;

    localparam int LINE_ADDR_LEN_DEF = 3;
    localparam int SET_ADDR_LEN_DEF  = 2;
    localparam int TAG_ADDR_LEN_DEF  = 6;
    localparam int DATA_W            = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } cache_state_e;

    typedef logic [DATA_W-1:0] line_word_t;

endpackage

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache with zero-latency hits and
// a line-at-a-time swap engine towards a registered-read word memory.
module dm_cache
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
    parameter int TAG_ADDR_LEN  = TAG_ADDR_LEN_DEF
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              rd_req,
    input  logic                                              wr_req,
    input  logic [LINE_ADDR_LEN+SET_ADDR_LEN+TAG_ADDR_LEN-1:0] addr,
    input  logic [DATA_W-1:0]                                 wr_data,
    output logic [DATA_W-1:0]                                 rd_data,
    output logic                                              miss,
    output logic [LINE_ADDR_LEN+SET_ADDR_LEN+TAG_ADDR_LEN-1:0] mem_addr,
    output logic                                              mem_wr_req,
    output logic [DATA_W-1:0]                                 mem_wr_data,
    input  logic [DATA_W-1:0]                                 mem_rd_data
);

    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int SET_SIZE  = 1 << SET_ADDR_LEN;
    localparam int CNT_W     = LINE_ADDR_LEN + 1;

    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [LINE_ADDR_LEN-1:0] req_off;

    line_word_t              data_arr [SET_SIZE][LINE_SIZE];
    logic [TAG_ADDR_LEN-1:0] tag_arr  [SET_SIZE];
    logic [SET_SIZE-1:0]     valid;
    logic [SET_SIZE-1:0]     dirty;

    cache_state_e             state;
    cache_state_e             state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [SET_ADDR_LEN-1:0]  lat_set;
    logic [TAG_ADDR_LEN-1:0]  lat_tag;
    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [LINE_ADDR_LEN-1:0] cap_idx;
    logic                     hit;
    logic                     last_out;
    logic                     last_in;

    assign {req_tag, req_set, req_off} = addr;

    assign hit  = (state == IDLE) && valid[req_set] && (tag_arr[req_set] == req_tag);
    assign miss = (rd_req | wr_req) & ~hit;

    assign rd_data = data_arr[req_set][req_off];

    // SWAP_IN runs one beat longer than the line: beat n stores the word addressed in beat n-1
    assign word_idx = cnt[LINE_ADDR_LEN-1:0];
    assign cap_idx  = LINE_ADDR_LEN'(cnt - CNT_W'(1));
    assign last_out = (cnt == CNT_W'(LINE_SIZE - 1));
    assign last_in  = (cnt == CNT_W'(LINE_SIZE));

    always_comb begin
        state_nxt   = state;
        mem_wr_req  = 1'b0;
        mem_addr    = addr;
        mem_wr_data = data_arr[lat_set][word_idx];
        case (state)
            IDLE: begin
                if (miss) begin
                    state_nxt = (valid[req_set] && dirty[req_set]) ? SWAP_OUT : SWAP_IN;
                end
            end
            SWAP_OUT: begin
                mem_wr_req = 1'b1;
                mem_addr   = {tag_arr[lat_set], lat_set, word_idx};
                if (last_out) begin
                    state_nxt = SWAP_IN;
                end
            end
            SWAP_IN: begin
                mem_addr = {lat_tag, lat_set, word_idx};
                if (last_in) begin
                    state_nxt = SWAP_IN_OK;
                end
            end
            SWAP_IN_OK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        cnt_nxt = ((state == IDLE) || (state_nxt != state)) ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (hit && wr_req) begin
                dirty[req_set] <= 1'b1;
            end
            if (state == SWAP_IN_OK) begin
                valid[lat_set] <= 1'b1;
                dirty[lat_set] <= 1'b0;
            end
        end
    end

    // Storage arrays and the latched miss address carry no reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (state == IDLE && miss) begin
            lat_tag <= req_tag;
            lat_set <= req_set;
        end
        if (hit && wr_req) begin
            data_arr[req_set][req_off] <= wr_data;
        end
        if (state == SWAP_IN && cnt != '0) begin
            data_arr[lat_set][cap_idx] <= mem_rd_data;
        end
        if (state == SWAP_IN_OK) begin
            tag_arr[lat_set] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_dm_cache.sv
// Scoreboard bench for dm_cache: word-level memory beside the cache, random
// traffic checked against a line-residency reference model.
module tb_dm_cache;

    localparam int WORDS = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic        wr_req;
    logic [10:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss;
    logic [10:0] mem_addr;
    logic        mem_wr_req;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    always #5 clk = ~clk;

    dm_cache dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .miss       (miss),
        .mem_addr   (mem_addr),
        .mem_wr_req (mem_wr_req),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // Backing memory with registered read
    logic [31:0] mem [WORDS];
    always @(posedge clk) begin
        if (mem_wr_req) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr];
    end

    // Reference model: expected backing memory plus which line each set holds
    logic [31:0] bk [WORDS];
    bit          m_valid [4];
    bit          m_dirty [4];
    int          m_tag   [4];
    logic [31:0] m_line  [4][8];

    typedef struct {
        bit          chk_rd;
        logic [10:0] a;
        logic [31:0] d;
        int          lat;
        int          nwr;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_fail = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;
    int mcyc = 0;
    int mwr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit rd, input bit wr, input logic [10:0] a,
                         input logic [31:0] d, output exp_t e);
        int s, t, o;
        s = int'(a[4:3]);
        t = int'(a[10:5]);
        o = int'(a[2:0]);
        e.a = a;
        e.chk_rd = rd && !wr;
        e.lat = 0;
        e.nwr = 0;
        if (!(m_valid[s] && m_tag[s] == t)) begin
            if (m_valid[s] && m_dirty[s]) begin
                e.lat = 19;
                e.nwr = 8;
                for (int i = 0; i < 8; i++) bk[m_tag[s]*32 + s*8 + i] = m_line[s][i];
            end else begin
                e.lat = 11;
            end
            for (int i = 0; i < 8; i++) m_line[s][i] = bk[t*32 + s*8 + i];
            m_valid[s] = 1'b1;
            m_dirty[s] = 1'b0;
            m_tag[s] = t;
        end
        if (wr) begin
            m_line[s][o] = d;
            m_dirty[s] = 1'b1;
        end
        e.d = m_line[s][o];
    endtask

    task automatic req(input bit rd, input bit wr, input logic [10:0] a, input logic [31:0] d);
        exp_t e;
        int start;
        model(rd, wr, a, d, e);
        q.push_back(e);
        rd_req = rd;
        wr_req = wr;
        addr = a;
        wr_data = d;
        start = done_cnt;
        for (int k = 0; k < 60 && done_cnt == start; k++) begin
            @(posedge clk);
            #1;
        end
        if (done_cnt == start) begin
            $display("FAIL req_timeout: addr 0x%0h never served, expected within %0d cycles", a, e.lat + 1);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec + 1, n_fail + 1);
            $fatal(1);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    // Monitor: counts stall cycles and memory writes, compares on every serve
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && (rd_req || wr_req)) begin
            if (mem_wr_req) mwr++;
            if (miss) begin
                mcyc++;
            end else if (q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_serve: addr 0x%0h served with no expectation queued", addr);
            end else begin
                e = q.pop_front();
                check("miss_cycles", 64'(mcyc), 64'(e.lat));
                check("mem_writes", 64'(mwr), 64'(e.nwr));
                check("served_addr", 64'(addr), 64'(e.a));
                if (e.chk_rd) check("rd_data", 64'(rd_data), 64'(e.d));
                mcyc = 0;
                mwr = 0;
                done_cnt++;
            end
        end
    end

    initial begin
        int bad;
        logic [10:0] a;
        int op;

        for (int k = 0; k < WORDS; k++) mem[k] = $urandom;
        mem[0] = 32'h0000000c;
        mem[1] = 32'h000000a8;
        mem[2] = 32'h00000034;
        mem[7] = 32'h00000087;
        mem[32] = 32'h00000099;
        for (int k = 0; k < WORDS; k++) bk[k] = mem[k];
        for (int s = 0; s < 4; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
            m_tag[s] = 0;
        end

        rst = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        addr = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_miss_idle", 64'(miss), 64'(0));
        check("rst_mem_wr_req", 64'(mem_wr_req), 64'(0));
        rd_req = 1'b1;
        #1;
        check("rst_miss_on_req", 64'(miss), 64'(1));
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Cold miss, then hits in the same line
        req(1, 0, 11'd0, 32'h0);
        req(1, 0, 11'd1, 32'h0);
        req(1, 0, 11'd7, 32'h0);

        // Write hit is held in the cache only
        req(0, 1, 11'd2, 32'hDEADBEEF);
        req(1, 0, 11'd2, 32'h0);
        check("mem2_before_evict", 64'(mem[2]), 64'h34);

        // Conflict miss on a dirty line forces write-back
        req(1, 0, 11'd32, 32'h0);
        check("mem2_after_evict", 64'(mem[2]), 64'hDEADBEEF);

        // Reset in the middle of SWAP_IN abandons the fill
        mon_en = 1'b0;
        rd_req = 1'b1;
        addr = 11'd0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_mem_wr_req", 64'(mem_wr_req), 64'(0));
        check("abort_miss", 64'(miss), 64'(1));
        rd_req = 1'b0;
        for (int s = 0; s < 4; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        req(1, 0, 11'd0, 32'h0);

        // Read and write together behave as a write
        req(1, 1, 11'd3, 32'h00000055);
        req(1, 0, 11'd3, 32'h0);

        // Random traffic over a few tags per set to mix hits, clean and dirty misses
        for (int n = 0; n < 400; n++) begin
            a = {6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            op = $urandom_range(0, 9);
            if (op < 5)      req(1, 0, a, 32'h0);
            else if (op < 9) req(0, 1, a, $urandom);
            else             req(1, 1, a, $urandom);
        end

        @(posedge clk);
        #1;
        bad = 0;
        for (int k = 0; k < WORDS; k++) if (mem[k] !== bk[k]) bad++;
        check("mem_image_diffs", 64'(bad), 64'(0));
        check("pending_expect", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
